if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the RISC core, succeeding the single-register IF stage. It drives a synchronous instruction memory and buffers returned instructions, with their PCs, in a QDEPTH-entry prefetch queue. Instructions are delivered to decode over a valid/ready handshake. Redirects come from a branch target, a hardware link-register stack (call/return) or the reset vector.

---
 rtl/if_prefetch_unit_if.sv | 51 +++++
 rtl/if_prefetch_unit.sv | 214 +++++++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_unit_if
//   Bus bundle for the instruction prefetch unit.
//   Groups the instruction-memory read port and the decode-side valid/ready
//   stream into one interface.
//
//   Signals:
//     imem_en     fetch unit -> memory   read strobe
//     imem_addr   fetch unit -> memory   read address (AW)
//     imem_rdata  memory -> fetch unit   read data, one cycle after imem_en (IW)
//     out_valid   fetch unit -> decode   queue head valid
//     out_ready   decode -> fetch unit   decode accepts head
//     out_instr   fetch unit -> decode   head instruction (IW)
//     out_pc      fetch unit -> decode   head PC (AW)
//
//   Modports:
//     master  the prefetch unit itself
//     slave   the memory/decode environment around it
// ----------------------------------------------------------------------------
interface if_prefetch_unit_if #(
  parameter int AW = 8,
  parameter int IW = 16
);
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// ----------------------------------------------------------------------------
// if_prefetch_unit
//   Instruction-fetch stage with a QDEPTH-entry prefetch queue and a
//   LR_DEPTH-entry hardware link-register stack.  Drives a synchronous
//   instruction memory (data returns exactly one cycle after the strobe),
//   buffers {instruction, PC} pairs and hands them to decode over valid/ready.
//
//   Ports:
//     clk       clock, all state on the rising edge
//     rst       synchronous active-high reset
//     bus       if_prefetch_unit_if.master: imem_en/imem_addr/imem_rdata and
//               out_valid/out_ready/out_instr/out_pc
//     pc_en     fetch enable (in-flight response still completes when low)
//     pc_sel    redirect: 00 none, 01 target, 10 return (pop LR), 11 RESET_VEC
//     target    branch target, used when pc_sel=01
//     lr_push   push lr_wdata onto the link stack
//     lr_wdata  return address to push
//     lr_empty  link stack empty
//     lr_err    sticky link-stack error (push on full / pop on empty)
//
//   Optional build macro IF_PERF_EN adds:
//     perf_fetch  16-bit saturating count of responses written to the queue
//     perf_flush  16-bit saturating count of redirect cycles
// ----------------------------------------------------------------------------
module if_prefetch_unit #(
  parameter int AW        = 8,
  parameter int IW        = 16,
  parameter int QDEPTH    = 4,
  parameter int LR_DEPTH  = 4,
  parameter int RESET_VEC = 0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_unit_if.master  bus,
  input  logic                pc_en,
  input  logic [1:0]          pc_sel,
  input  logic [AW-1:0]       target,
  input  logic                lr_push,
  input  logic [AW-1:0]       lr_wdata,
  output logic                lr_empty,
  output logic                lr_err
`ifdef IF_PERF_EN
  ,
  output logic [15:0]         perf_fetch,
  output logic [15:0]         perf_flush
`endif
);

  localparam int QPW = $clog2(QDEPTH);
  localparam int LPW = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;

  localparam logic [AW-1:0]  RST_PC = AW'(RESET_VEC);
  localparam logic [QPW+1:0] QD     = (QPW+2)'(QDEPTH);
  localparam logic [LPW:0]   LRD    = (LPW+1)'(LR_DEPTH);
  localparam logic [LPW-1:0] LR_TOP_MAX = LPW'(LR_DEPTH - 1);

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_TARGET = 2'b01;
  localparam logic [1:0] SEL_RET    = 2'b10;
  localparam logic [1:0] SEL_RST    = 2'b11;

  // fetch state
  logic [AW-1:0] fetch_pc_reg, fetch_pc_next;
  logic          inflight_reg;
  logic [AW-1:0] inflight_pc_reg;

  // prefetch queue
  logic [IW-1:0] q_instr_mem [QDEPTH];
  logic [AW-1:0] q_pc_mem    [QDEPTH];
  logic [QPW-1:0] q_rd_ptr_reg, q_wr_ptr_reg;
  logic [QPW:0]   q_count_reg;

  // link stack (circular so that a push on full drops the oldest entry)
  logic [AW-1:0]  lr_mem [LR_DEPTH];
  logic [LPW-1:0] lr_top_reg;
  logic [LPW:0]   lr_count_reg;
  logic           lr_err_reg;

  logic redirect, pop_now, deq, push_now, credit_ok, issue;
  logic lr_pop, lr_full;
  logic [LPW-1:0] lr_top_inc, lr_top_dec, lr_wr_addr;
  logic [AW-1:0]  lr_top_val;

  assign redirect = (pc_sel != SEL_NONE);
  assign pop_now  = bus.out_valid & bus.out_ready;
  // A redirect flushes the queue, so the head handed over this cycle is dropped.
  assign deq      = pop_now & ~redirect;
  // Latency is exactly one cycle, so the response in flight is arriving now;
  // a redirect this cycle kills it simply by not writing it.
  assign push_now = inflight_reg & ~redirect;

  // A slot freed by this cycle's pop may be reused by this cycle's request,
  // which lets a full queue with ready decode sustain one instruction per
  // cycle.  count + inflight can never exceed QDEPTH, so no overflow.
  assign credit_ok = ({1'b0, q_count_reg} + (QPW+2)'(inflight_reg))
                     < (QD + (QPW+2)'(pop_now));
  assign issue     = ~rst & pc_en & ~redirect & credit_ok;

  assign lr_pop     = (pc_sel == SEL_RET);
  assign lr_empty   = (lr_count_reg == '0);
  assign lr_full    = (lr_count_reg == LRD);
  assign lr_err     = lr_err_reg;
  assign lr_top_inc = (lr_top_reg == LR_TOP_MAX) ? '0 : lr_top_reg + 1'b1;
  assign lr_top_dec = (lr_top_reg == '0) ? LR_TOP_MAX : lr_top_reg - 1'b1;
  assign lr_top_val = lr_mem[lr_top_reg];
  // Push+pop on a non-empty stack overwrites the top in place; otherwise a
  // push lands one slot above the current top.
  assign lr_wr_addr = (lr_pop & ~lr_empty) ? lr_top_reg : lr_top_inc;

  // ---------------------------------------------------------------- fetch PC
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    case (pc_sel)
      SEL_TARGET: fetch_pc_next = target;
      SEL_RET:    fetch_pc_next = lr_empty ? RST_PC : lr_top_val;
      SEL_RST:    fetch_pc_next = RST_PC;
      default:    if (issue) fetch_pc_next = fetch_pc_reg + AW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RST_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= RST_PC;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= fetch_pc_reg;
    end
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc_reg;

  // ----------------------------------------------------------- prefetch queue
  always_ff @(posedge clk) begin
    if (push_now && !rst) begin
      q_instr_mem[q_wr_ptr_reg] <= bus.imem_rdata;
      q_pc_mem[q_wr_ptr_reg]    <= inflight_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      q_rd_ptr_reg <= '0;
      q_wr_ptr_reg <= '0;
      q_count_reg  <= '0;
    end else begin
      if (push_now) q_wr_ptr_reg <= q_wr_ptr_reg + 1'b1;
      if (deq)      q_rd_ptr_reg <= q_rd_ptr_reg + 1'b1;
      case ({push_now, deq})
        2'b10:   q_count_reg <= q_count_reg + 1'b1;
        2'b01:   q_count_reg <= q_count_reg - 1'b1;
        default: q_count_reg <= q_count_reg;
      endcase
    end
  end

  assign bus.out_valid = (q_count_reg != '0);
  // Head fields read as zero while the queue is empty.
  assign bus.out_instr = bus.out_valid ? q_instr_mem[q_rd_ptr_reg] : '0;
  assign bus.out_pc    = bus.out_valid ? q_pc_mem[q_rd_ptr_reg]    : '0;

  // --------------------------------------------------------------- link stack
  always_ff @(posedge clk) begin
    if (lr_push && !rst) lr_mem[lr_wr_addr] <= lr_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_top_reg   <= '0;
      lr_count_reg <= '0;
      lr_err_reg   <= 1'b0;
    end else if (lr_pop && lr_push) begin
      if (lr_empty) begin
        // Pop fails, the push still lands.
        lr_err_reg   <= 1'b1;
        lr_top_reg   <= lr_top_inc;
        lr_count_reg <= (LPW+1)'(1);
      end
    end else if (lr_push) begin
      lr_top_reg <= lr_top_inc;
      if (lr_full) lr_err_reg   <= 1'b1;
      else         lr_count_reg <= lr_count_reg + 1'b1;
    end else if (lr_pop) begin
      if (lr_empty) begin
        lr_err_reg <= 1'b1;
      end else begin
        lr_top_reg   <= lr_top_dec;
        lr_count_reg <= lr_count_reg - 1'b1;
      end
    end
  end

`ifdef IF_PERF_EN
  // ------------------------------------------------------ performance counters
  logic [15:0] perf_fetch_reg, perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (push_now && perf_fetch_reg != 16'hFFFF) perf_fetch_reg <= perf_fetch_reg + 1'b1;
      if (redirect && perf_flush_reg != 16'hFFFF) perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign perf_fetch = perf_fetch_reg;
  assign perf_flush = perf_flush_reg;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_unit
//   Directed testbench for if_prefetch_unit (AW=8, IW=16, QDEPTH=4,
//   LR_DEPTH=4, RESET_VEC=0).  The memory model returns ~{8'h00, addr} one
//   cycle after imem_en.  Inputs are applied at the falling edge and outputs
//   are sampled 1 time unit later, i.e. mid-cycle.
// ----------------------------------------------------------------------------
module tb_if_prefetch_unit;
  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic [AW-1:0] target;
  logic          lr_push;
  logic [AW-1:0] lr_wdata;
  logic          lr_empty;
  logic          lr_err;
`ifdef IF_PERF_EN
  logic [15:0]   perf_fetch;
  logic [15:0]   perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_prefetch_unit_if #(.AW(AW), .IW(IW)) bus ();

  if_prefetch_unit #(
    .AW(AW), .IW(IW), .QDEPTH(4), .LR_DEPTH(4), .RESET_VEC(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .target   (target),
    .lr_push  (lr_push),
    .lr_wdata (lr_wdata),
    .lr_empty (lr_empty),
    .lr_err   (lr_err)
`ifdef IF_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_flush (perf_flush)
`endif
  );

  // synchronous instruction memory: data valid exactly one cycle after imem_en
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_en ? ~{8'h00, bus.imem_addr} : 16'h0BAD;
  end

  function automatic logic [31:0] exp_instr(input logic [7:0] pc);
    logic [15:0] v;
    v = ~{8'h00, pc};
    return {16'h0000, v};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %-16s got=%0h", tag, got);
    end
  endtask

  // advance to the next falling edge; redirect and push are single-cycle pulses
  task automatic tick();
    @(negedge clk);
    pc_sel  = 2'b00;
    lr_push = 1'b0;
  endtask

  // leaves rst asserted at a falling edge after two reset clock edges
  task automatic apply_reset();
    tick();
    rst = 1'b1;
    pc_en = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; pc_en = 1'b0; pc_sel = 2'b00; target = '0;
    lr_push = 1'b0; lr_wdata = '0; bus.out_ready = 1'b0;

    // ---------------- reset state
    apply_reset();
    #1;
    check_val("rst_imem_en",   bus.imem_en,   0);
    check_val("rst_imem_addr", bus.imem_addr, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_instr", bus.out_instr, 0);
    check_val("rst_out_pc",    bus.out_pc,    0);
    check_val("rst_lr_empty",  lr_empty,      1);
    check_val("rst_lr_err",    lr_err,        0);

    // ---------------- streaming from reset
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b1; #1;
    check_val("s_c0_en",   bus.imem_en,   1);
    check_val("s_c0_addr", bus.imem_addr, 0);
    tick(); #1;
    check_val("s_c1_addr",  bus.imem_addr, 1);
    check_val("s_c1_valid", bus.out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check_val("s_valid", bus.out_valid, 1);
      check_val("s_pc",    bus.out_pc,    k);
      check_val("s_instr", bus.out_instr, exp_instr(8'(k)));
      check_val("s_addr",  bus.imem_addr, k + 2);
    end

    // ---------------- back-pressure: exactly four captured
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b0; #1;
    n = int'(bus.imem_en);
    for (int i = 1; i < 8; i++) begin
      tick(); #1;
      n += int'(bus.imem_en);
    end
    check_val("bp_issues",  n, 4);
    check_val("bp_en_low",  bus.imem_en,   0);
    check_val("bp_valid",   bus.out_valid, 1);
    check_val("bp_head_pc", bus.out_pc,    0);
    check_val("bp_head_in", bus.out_instr, 32'hFFFF);
    tick(); bus.out_ready = 1'b1; #1;
    check_val("bp_resume_en", bus.imem_en,   1);
    check_val("bp_resume_ad", bus.imem_addr, 4);
    check_val("bp_pc0",       bus.out_pc,    0);
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      check_val("bp_pc", bus.out_pc, k);
    end

    // ---------------- redirect with 3 queued + 1 in flight
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b0;
    tick(); tick(); tick();
    tick(); pc_sel = 2'b01; target = 8'h40; #1;
    check_val("rd_pre_valid", bus.out_valid, 1);
    check_val("rd_no_issue",  bus.imem_en,   0);
    tick(); bus.out_ready = 1'b1; #1;
    check_val("rd_flush",   bus.out_valid, 0);
    check_val("rd_en",      bus.imem_en,   1);
    check_val("rd_addr",    bus.imem_addr, 8'h40);
    tick(); #1;
    check_val("rd_killed",  bus.out_valid, 0);
    tick(); #1;
    check_val("rd_pc40",    bus.out_pc,    8'h40);
    check_val("rd_in40",    bus.out_instr, exp_instr(8'h40));
    tick(); #1;
    check_val("rd_pc41",    bus.out_pc,    8'h41);

    // ---------------- link stack push/pop
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b0; bus.out_ready = 1'b1;
    lr_push = 1'b1; lr_wdata = 8'h10; #1;
    check_val("lr_empty0", lr_empty, 1);
    tick(); lr_push = 1'b1; lr_wdata = 8'h20; #1;
    check_val("lr_nonempty", lr_empty, 0);
    tick(); pc_en = 1'b1; pc_sel = 2'b10; #1;
    check_val("lr_pop_noiss", bus.imem_en, 0);
    tick(); pc_sel = 2'b10; #1;
    check_val("lr_pop1_addr", bus.imem_addr, 8'h20);
    tick(); #1;
    check_val("lr_pop2_addr", bus.imem_addr, 8'h10);
    check_val("lr_pop2_en",   bus.imem_en,   1);
    check_val("lr_pop2_emp",  lr_empty,      1);
    check_val("lr_pop2_err",  lr_err,        0);
    tick(); pc_sel = 2'b10;
    tick(); #1;
    check_val("lr_pop3_addr", bus.imem_addr, 0);
    check_val("lr_pop3_err",  lr_err,        1);
    check_val("lr_pop3_emp",  lr_empty,      1);

    // ---------------- push on full drops oldest
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); lr_push = 1'b1; lr_wdata = 8'(8'h11 + i); #1;
      check_val("lrf_err_pre", lr_err, 0);
    end
    tick(); #1;
    check_val("lrf_err_post", lr_err, 1);
    for (int j = 0; j < 4; j++) begin
      tick(); pc_sel = 2'b10;
      tick(); #1;
      check_val("lrf_pop", bus.imem_addr, 8'h15 - j);
    end
    tick(); pc_sel = 2'b10;
    tick(); #1;
    check_val("lrf_pop_emp", bus.imem_addr, 0);
    check_val("lrf_empty",   lr_empty,      1);

    // ---------------- simultaneous push + pop
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b0; bus.out_ready = 1'b1;
    tick(); lr_push = 1'b1; lr_wdata = 8'h10;
    tick(); pc_en = 1'b1; pc_sel = 2'b10; lr_push = 1'b1; lr_wdata = 8'h30;
    tick(); #1;
    check_val("pp_old_top", bus.imem_addr, 8'h10);
    check_val("pp_depth",   lr_empty,      0);
    tick(); pc_sel = 2'b10;
    tick(); #1;
    check_val("pp_new_top", bus.imem_addr, 8'h30);
    check_val("pp_empty",   lr_empty,      1);
    check_val("pp_err",     lr_err,        0);

    // ---------------- PC wrap, then pc_en drop drains in-flight
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b1;
    tick(); pc_sel = 2'b01; target = 8'hFE;
    tick(); #1;
    check_val("wr_addr_fe", bus.imem_addr, 8'hFE);
    tick(); #1;
    check_val("wr_addr_ff", bus.imem_addr, 8'hFF);
    tick(); #1;
    check_val("wr_addr_00", bus.imem_addr, 8'h00);
    check_val("wr_pc_fe",   bus.out_pc,    8'hFE);
    tick(); pc_en = 1'b0; #1;
    check_val("wr_pc_ff",   bus.out_pc,    8'hFF);
    check_val("wr_en_off",  bus.imem_en,   0);
    tick(); #1;
    check_val("wr_pc_00",   bus.out_pc,    8'h00);
    check_val("wr_in_00",   bus.out_instr, 32'hFFFF);
    tick(); #1;
    check_val("wr_drained", bus.out_valid, 0);

    // ---------------- reset mid-operation
    apply_reset();
    tick(); rst = 1'b0; pc_en = 1'b1; bus.out_ready = 1'b0; pc_sel = 2'b10;
    tick(); tick(); tick();
    tick(); #1;
    check_val("mr_pre_err",   lr_err,        1);
    check_val("mr_pre_valid", bus.out_valid, 1);
    tick(); rst = 1'b1; #1;
    check_val("mr_rst_en",    bus.imem_en,   0);
    tick(); rst = 1'b0; #1;
    check_val("mr_valid",     bus.out_valid, 0);
    check_val("mr_err",       lr_err,        0);
    check_val("mr_addr",      bus.imem_addr, 0);
    check_val("mr_en",        bus.imem_en,   1);
`ifdef IF_PERF_EN
    check_val("mr_perf_fetch", perf_fetch, 0);
    check_val("mr_perf_flush", perf_flush, 0);
`endif
    tick(); #1;
    check_val("mr_nocapture", bus.out_valid, 0);
    tick(); #1;
    check_val("mr_first_pc",  bus.out_pc,    0);
    check_val("mr_first_in",  bus.out_instr, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
